// File: rtl/enc_display_if.sv
// Bus between the encoder decoder and its display stage: position and step
// pulses in, segment drive, digit select and direction LEDs out.
interface enc_display_if;
  logic [4:0] pos;
  logic       step_up;
  logic       step_dn;
  logic [6:0] seg;
  logic       digit_sel;
  logic [1:0] dir_led;

  modport master (
    output pos, step_up, step_dn,
    input  seg, digit_sel, dir_led
  );

  modport slave (
    input  pos, step_up, step_dn,
    output seg, digit_sel, dir_led
  );
endinterface

// File: rtl/enc_display.sv
// Display stage for the rotary-encoder decoder: shows the 0-19 position on a
// two-digit multiplexed seven-segment Pmod and stretches step pulses into
// visible direction LEDs.
module enc_display #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned STRETCH_CYCLES = 10000000
) (
  input logic          clk,
  input logic          BTN,
  enc_display_if.slave bus
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned StrW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [RefW-1:0] RefMax      = RefW'(REFRESH_DIV - 1);
  localparam logic [StrW-1:0] StretchLoad = StrW'(STRETCH_CYCLES);

  localparam logic [6:0] SegDash  = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;
  localparam logic [6:0] SegOne   = 7'h06;

  logic [4:0]      pos_q;
  logic [RefW-1:0] ref_cnt, ref_cnt_d;
  logic            digit_sel, sel_next, ref_wrap;
  logic [6:0]      seg, seg_d, ones_code;
  logic            tens;
  logic [3:0]      ones;
  logic [StrW-1:0] up_cnt, up_cnt_d, dn_cnt, dn_cnt_d;
  logic [1:0]      dir_led;

  // Refresh counter; sel_next is the digit select registered this cycle, so
  // seg is computed against it and the two outputs never skew.
  always_comb begin
    ref_wrap  = (ref_cnt == RefMax);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt + RefW'(1);
    sel_next  = digit_sel ^ ref_wrap;
  end

  // Decimal split of the registered position and ones-digit segment code.
  always_comb begin
    tens = (pos_q >= 5'd10);
    ones = tens ? 4'(pos_q - 5'd10) : pos_q[3:0];
    case (ones)
      4'd0:    ones_code = 7'h3F;
      4'd1:    ones_code = 7'h06;
      4'd2:    ones_code = 7'h5B;
      4'd3:    ones_code = 7'h4F;
      4'd4:    ones_code = 7'h66;
      4'd5:    ones_code = 7'h6D;
      4'd6:    ones_code = 7'h7D;
      4'd7:    ones_code = 7'h07;
      4'd8:    ones_code = 7'h7F;
      4'd9:    ones_code = 7'h6F;
      default: ones_code = SegDash;
    endcase
  end

  // Segment selection: dash for out-of-range, leading-zero blanking on tens.
  always_comb begin
    seg_d = ones_code;
    if (pos_q > 5'd19) begin
      seg_d = SegDash;
    end else if (sel_next) begin
      seg_d = tens ? SegOne : SegBlank;
    end
  end

  // Pulse stretchers: last direction wins; a simultaneous up+down is ignored.
  always_comb begin
    up_cnt_d = (up_cnt != '0) ? up_cnt - StrW'(1) : '0;
    dn_cnt_d = (dn_cnt != '0) ? dn_cnt - StrW'(1) : '0;
    if (bus.step_up && !bus.step_dn) begin
      up_cnt_d = StretchLoad;
      dn_cnt_d = '0;
    end else if (bus.step_dn && !bus.step_up) begin
      dn_cnt_d = StretchLoad;
      up_cnt_d = '0;
    end
  end

  // All state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (BTN) begin
      pos_q     <= '0;
      ref_cnt   <= '0;
      digit_sel <= 1'b0;
      seg       <= SegBlank;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      dir_led   <= 2'b00;
    end else begin
      pos_q     <= bus.pos;
      ref_cnt   <= ref_cnt_d;
      digit_sel <= sel_next;
      seg       <= seg_d;
      up_cnt    <= up_cnt_d;
      dn_cnt    <= dn_cnt_d;
      dir_led   <= {dn_cnt != '0, up_cnt != '0};
    end
  end

  assign bus.seg       = seg;
  assign bus.digit_sel = digit_sel;
  assign bus.dir_led   = dir_led;

endmodule

// File: tb/tb_enc_display.sv
// Bench for enc_display: directed scenarios plus random traffic, every cycle
// compared against an edge-indexed behavioural model.
module tb_enc_display;

  localparam int unsigned RefDiv  = 4;
  localparam int unsigned Stretch = 8;

  logic clk = 1'b0;
  logic BTN;

  enc_display_if bus ();

  enc_display #(
    .REFRESH_DIV   (RefDiv),
    .STRETCH_CYCLES(Stretch)
  ) dut (
    .clk(clk),
    .BTN(BTN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: absolute edge index, edges since reset, displayed position,
  // and the last edge index at which each direction LED is still lit.
  int ec     = 0;
  int k      = 0;
  int m_posq = 0;
  int up_end = -1;
  int dn_end = -1;
  logic [6:0] m_seg;
  logic       m_sel;
  logic [1:0] m_dir;
  logic [6:0] digit_code [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic tick(input logic b, input int p, input logic u, input logic d);
    BTN         = b;
    bus.pos     = 5'(p);
    bus.step_up = u;
    bus.step_dn = d;
    @(posedge clk);
    ec++;
    if (b) begin
      k = 0; m_posq = 0; up_end = -1; dn_end = -1;
      m_seg = 7'h00; m_sel = 1'b0; m_dir = 2'b00;
    end else begin
      k++;
      m_sel = ((k / RefDiv) % 2) == 1;
      if (m_posq > 19)     m_seg = 7'h40;
      else if (m_sel)      m_seg = (m_posq >= 10) ? 7'h06 : 7'h00;
      else                 m_seg = digit_code[m_posq % 10];
      m_dir = {ec <= dn_end, ec <= up_end};
      if (u && !d) begin
        up_end = ec + Stretch;
        dn_end = ec;
      end else if (d && !u) begin
        dn_end = ec + Stretch;
        up_end = ec;
      end
      m_posq = p;
    end
    #1;
    check("seg", bus.seg, m_seg);
    check("digit_sel", {6'd0, bus.digit_sel}, {6'd0, m_sel});
    check("dir_led", {5'd0, bus.dir_led}, {5'd0, m_dir});
  endtask

  int lit;

  initial begin
    // Reset held with pos=7, then release.
    for (int i = 0; i < 3; i++) tick(1'b1, 7, 1'b0, 1'b0);
    tick(1'b0, 7, 1'b0, 1'b0);
    check("first_seg_after_release", bus.seg, 7'h3F);
    tick(1'b0, 7, 1'b0, 1'b0);
    check("release_seg_7", bus.seg, 7'h07);

    // Multiplex with two digits, then leading-zero blanking.
    for (int i = 0; i < 16; i++) tick(1'b0, 13, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 5, 1'b0, 1'b0);

    // Full range sweep and out-of-range values.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 8; i++) tick(1'b0, p, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 20, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 31, 1'b0, 1'b0);
    check("dash_seg", bus.seg, 7'h40);

    // Single stretch: lit for exactly eight cycles.
    lit = 0;
    tick(1'b0, 3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 3, 1'b0, 1'b0);
      if (bus.dir_led == 2'b01) lit++;
    end
    check("stretch_len", 7'(lit), 7'd8);

    // Retrigger five edges later extends to thirteen cycles.
    lit = 0;
    tick(1'b0, 3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 3, 1'b0, 1'b0);
      if (bus.dir_led == 2'b01) lit++;
    end
    tick(1'b0, 3, 1'b1, 1'b0);
    if (bus.dir_led == 2'b01) lit++;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 3, 1'b0, 1'b0);
      if (bus.dir_led == 2'b01) lit++;
    end
    check("retrigger_len", 7'(lit), 7'd13);

    // Up then down three cycles later: down wins.
    tick(1'b0, 9, 1'b1, 1'b0);
    tick(1'b0, 9, 1'b0, 1'b0);
    tick(1'b0, 9, 1'b0, 1'b0);
    tick(1'b0, 9, 1'b0, 1'b1);
    lit = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 9, 1'b0, 1'b0);
      if (bus.dir_led == 2'b10) lit++;
    end
    check("override_len", 7'(lit), 7'd8);

    // Simultaneous pulses with idle counters: nothing lights.
    tick(1'b0, 9, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 9, 1'b0, 1'b0);
    check("illegal_overlap", {5'd0, bus.dir_led}, 7'd0);

    // Reset mid-stretch with the refresh counter at 2.
    tick(1'b0, 14, 1'b1, 1'b0);
    tick(1'b0, 14, 1'b0, 1'b0);
    for (int i = 0; i < 4 && (k % RefDiv) != 2; i++) tick(1'b0, 14, 1'b0, 1'b0);
    check("pre_reset_dir", {5'd0, bus.dir_led}, 7'd1);
    tick(1'b1, 14, 1'b0, 1'b0);
    check("mid_reset_seg", bus.seg, 7'h00);
    check("mid_reset_dir", {5'd0, bus.dir_led}, 7'd0);
    check("mid_reset_sel", {6'd0, bus.digit_sel}, 7'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(0, 199) == 0, int'($urandom_range(0, 23)),
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_display.md
# enc_display

Downstream display stage for the PMOD rotary-encoder decoder. Consumes the decoder's 5-bit position (0–19) and its single-cycle up/down step pulses. Drives a two-digit multiplexed Pmod SSD with the position in decimal. Stretches each step pulse into a visible direction LED.

## Interface

Parameters:
- REFRESH_DIV, 100000: cycles per digit before `digit_sel` toggles (1 ms at 100 MHz); must be ≥ 2.
- STRETCH_CYCLES, 10000000: cycles a direction LED stays lit after a step pulse (100 ms at 100 MHz); must be ≥ 1.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge.
- BTN  in  1  reset: synchronous, active-high.
- pos  in  5  encoder position; legal range 0–19.
- step_up  in  1  single-cycle pulse: one clockwise detent.
- step_dn  in  1  single-cycle pulse: one counter-clockwise detent.
- seg  out  7  segment drive, active-high, {g,f,e,d,c,b,a}.
- digit_sel  out  1  Pmod SSD cathode select: 0 = ones digit, 1 = tens digit.
- dir_led  out  2  [0] = recent up step, [1] = recent down step.

## Operation

- **Input register.** `pos_q` <= `pos` every cycle.
- **Refresh counter** `ref_cnt`:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle, `digit_sel` toggles.
  - Full display period is 2·REFRESH_DIV cycles.
- **Decode**, from `pos_q`:
  - tens = 1 if `pos_q` ≥ 10, else 0.
  - ones = `pos_q` − 10·tens.
- **Segment codes** (`seg` is registered):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, dash=0x40, blank=0x00.
- **Segment selection** (`sel_next` is the `digit_sel` value being registered in the same cycle):
  - `sel_next`=0 → code(ones).
  - `sel_next`=1 and tens=1 → 0x06.
  - `sel_next`=1 and tens=0 → blank (leading-zero blanking).
  - `pos_q` > 19 → dash on both digits. Out-of-range input is never displayed as a number.
- **Alignment.** `seg` and `digit_sel` update in the same cycle and are always mutually consistent; never one cycle skewed.
- **Pulse stretchers**, one counter each (`up_cnt`, `dn_cnt`), width ⌈log2(STRETCH_CYCLES+1)⌉:
  - `step_up` alone: `up_cnt` <= STRETCH_CYCLES and `dn_cnt` <= 0 (last direction wins).
  - `step_dn` alone: mirror of `step_up`.
  - Both asserted in the same cycle: treated as illegal; both counters keep decrementing normally and neither reloads.
  - Retrigger while lit reloads the counter to STRETCH_CYCLES.
  - Otherwise each nonzero counter decrements by 1.
  - `dir_led[0]` = (`up_cnt` != 0) and `dir_led[1]` = (`dn_cnt` != 0), both registered from counter state.

## Timing

- **Reset** (BTN high at a clock edge), all state cleared on that edge:
  - `ref_cnt`=0, `digit_sel`=0, `pos_q`=0, `seg`=0x00, `up_cnt`=`dn_cnt`=0, `dir_led`=2'b00.
  - BTN held high keeps every output at its reset value.
  - Reset mid-stretch or mid-refresh discards all progress.
- **First cycle after reset release:** `seg` shows the ones digit of `pos_q` (0 → 0x3F).
- **Position latency:** `pos` change at edge N → `pos_q` at N+1 → `seg` reflects it at N+2, provided the ones digit is being displayed.
- **Direction LED latency:** step pulse sampled at edge N → `dir_led` bit high from N+1 for exactly STRETCH_CYCLES cycles, absent retrigger or cancel.
- **Wrap events from the decoder** (19→0 or 0→19) need no special handling: the display follows `pos`.

## Test plan

All scenarios use REFRESH_DIV=4 and STRETCH_CYCLES=8.

- **Reset:** hold BTN 3 cycles with `pos`=7 → `seg`=0x00, `dir_led`=00, `digit_sel`=0 throughout. After release, `seg`=0x07 within 2 cycles.
- **Multiplex:** `pos`=13 held →
  - `digit_sel` toggles every 4 cycles.
  - `seg`=0x4F when `digit_sel`=0, `seg`=0x06 when `digit_sel`=1.
  - `pos`=5 → tens slot shows 0x00.
- **Range:** sweep `pos` 0..19, checking both digits for every value. `pos`=20 and `pos`=31 → `seg`=0x40 on both digits.
- **Stretch:** single `step_up` pulse → `dir_led`=01 for exactly 8 cycles, then 00. A second pulse at cycle 5 extends the lit time to 13 cycles total.
- **Direction override and illegal overlap:**
  - `step_up`, then `step_dn` 3 cycles later → `dir_led` goes 01 → 10 on the cycle after `step_dn`, stays 10 for 8 cycles.
  - `step_up` and `step_dn` asserted together with both counters 0 → `dir_led` stays 00.
- **Reset mid-operation:** BTN asserted while `dir_led`=01 and `ref_cnt`=2 → next cycle `dir_led`=00, `digit_sel`=0, `seg`=0x00.
